// File: rtl/mult_hilo_ctrl_if.sv
// Pipeline/multiplier-side bundle for the HI/LO multiply sequencer.
// The slave modport is the controller's view of the bundle.
interface mult_hilo_ctrl_if #(
  parameter int BIT_WIDTH = 32
);
  logic                   start;
  logic [1:0]             op;
  logic [BIT_WIDTH-1:0]   rs_val;
  logic [BIT_WIDTH-1:0]   rt_val;
  logic                   flush;
  logic                   rd_req;
  logic                   ready;
  logic                   busy;
  logic                   done;
  logic                   hilo_stall;
  logic [BIT_WIDTH-1:0]   hi;
  logic [BIT_WIDTH-1:0]   lo;
  logic [BIT_WIDTH-1:0]   mul_a;
  logic [BIT_WIDTH-1:0]   mul_b;
  logic [2*BIT_WIDTH-1:0] mul_p;

  modport master (
    output start, op, rs_val, rt_val, flush, rd_req, mul_p,
    input  ready, busy, done, hilo_stall, hi, lo, mul_a, mul_b
  );

  modport slave (
    input  start, op, rs_val, rt_val, flush, rd_req, mul_p,
    output ready, busy, done, hilo_stall, hi, lo, mul_a, mul_b
  );
endinterface

// File: rtl/mult_hilo_ctrl.sv
// MIPS multiply sequencer: feeds operand magnitudes to an external unsigned
// multiplier of latency DELAY, sign-corrects the product, and owns HI/LO.
module mult_hilo_ctrl #(
  parameter int BIT_WIDTH = 32,
  parameter int DELAY     = 0
) (
  input logic           clk,
  input logic           rst,
  mult_hilo_ctrl_if.slave bus
);
  localparam int CNT_W = (DELAY > 0) ? $clog2(DELAY + 1) : 1;
  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_MTHI  = 2'b10;
  localparam logic [1:0] OP_MTLO  = 2'b11;

  typedef enum logic {IDLE, WAIT} state_t;

  state_t                 state_q;
  logic [CNT_W-1:0]       cnt_q;
  logic                   neg_q;
  logic                   busy_q;
  logic                   done_q;
  logic [BIT_WIDTH-1:0]   hi_q;
  logic [BIT_WIDTH-1:0]   lo_q;
  logic [BIT_WIDTH-1:0]   mul_a_q;
  logic [BIT_WIDTH-1:0]   mul_b_q;

  logic                   signed_op;
  logic [BIT_WIDTH-1:0]   mag_a_d;
  logic [BIT_WIDTH-1:0]   mag_b_d;
  logic                   neg_d;
  logic [2*BIT_WIDTH-1:0] prod_d;

  // The most negative operand negates to itself, which is its exact unsigned magnitude.
  always_comb begin
    signed_op = (bus.op == OP_MULT);
    mag_a_d   = (signed_op && bus.rs_val[BIT_WIDTH-1]) ? -bus.rs_val : bus.rs_val;
    mag_b_d   = (signed_op && bus.rt_val[BIT_WIDTH-1]) ? -bus.rt_val : bus.rt_val;
    neg_d     = signed_op && (bus.rs_val[BIT_WIDTH-1] ^ bus.rt_val[BIT_WIDTH-1]);
    prod_d    = neg_q ? -bus.mul_p : bus.mul_p;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      mul_a_q <= '0;
      mul_b_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start && !bus.flush) begin
            case (bus.op)
              OP_MTHI: hi_q <= bus.rs_val;
              OP_MTLO: lo_q <= bus.rs_val;
              OP_MULT, OP_MULTU: begin
                mul_a_q <= mag_a_d;
                mul_b_q <= mag_b_d;
                neg_q   <= neg_d;
                cnt_q   <= CNT_W'(DELAY);
                busy_q  <= 1'b1;
                state_q <= WAIT;
              end
              default: ;
            endcase
          end
        end
        WAIT: begin
          if (bus.flush) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else begin
            {hi_q, lo_q} <= prod_d;
            busy_q       <= 1'b0;
            done_q       <= 1'b1;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy       = busy_q;
  assign bus.ready      = ~busy_q;
  assign bus.done       = done_q;
  assign bus.hilo_stall = busy_q & bus.rd_req;
  assign bus.hi         = hi_q;
  assign bus.lo         = lo_q;
  assign bus.mul_a      = mul_a_q;
  assign bus.mul_b      = mul_b_q;
endmodule

// File: tb/tb_mult_hilo_ctrl.sv
// Self-checking bench for mult_hilo_ctrl with a DELAY-cycle pipelined multiplier model.
module tb_mult_hilo_ctrl;
  localparam int W     = 32;
  localparam int DELAY = 3;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  logic [W-1:0] exp_hi;
  logic [W-1:0] exp_lo;

  mult_hilo_ctrl_if #(.BIT_WIDTH(W)) bus ();

  mult_hilo_ctrl #(.BIT_WIDTH(W), .DELAY(DELAY)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External multiplier: product of the registered operands appears DELAY edges later.
  logic [2*W-1:0] pipe [DELAY];
  always @(posedge clk) begin
    pipe[0] <= {{W{1'b0}}, bus.mul_a} * {{W{1'b0}}, bus.mul_b};
    for (int i = 1; i < DELAY; i++) pipe[i] <= pipe[i-1];
  end
  assign bus.mul_p = pipe[DELAY-1];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2*W-1:0] ref_prod(input logic [1:0] op, input logic [W-1:0] a,
                                              input logic [W-1:0] b);
    longint sa;
    longint sb;
    longint unsigned ua;
    longint unsigned ub;
    if (op == 2'b00) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return 64'(sa * sb);
    end
    ua = {32'b0, a};
    ub = {32'b0, b};
    return 64'(ua * ub);
  endfunction

  task automatic check_hilo(input string name);
    checks++;
    if (bus.hi !== exp_hi || bus.lo !== exp_lo) begin
      errors++;
      $display("FAIL %s: hi/lo=%h/%h expected %h/%h", name, bus.hi, bus.lo, exp_hi, exp_lo);
    end
  endtask

  // Issues a multiply and follows it to the cycle in which done is high.
  // When hold_start is set, start stays high with junk operands while busy.
  task automatic run_mul(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic rd, input logic hold_start, input string name);
    int cycles;
    logic [2*W-1:0] p;
    p = ref_prod(op, a, b);
    bus.start = 1'b1; bus.op = op; bus.rs_val = a; bus.rt_val = b; bus.rd_req = rd;
    tick();
    if (hold_start) begin
      bus.op = 2'b01; bus.rs_val = $urandom; bus.rt_val = $urandom;
    end else begin
      bus.start = 1'b0;
    end
    cycles = 0;
    while (bus.busy === 1'b1 && cycles < 20) begin
      cycles++;
      checks++;
      if (bus.ready !== 1'b0 || bus.done !== 1'b0 || bus.hilo_stall !== rd) begin
        errors++;
        $display("FAIL %s busy-cycle: ready=%b done=%b stall=%b expected 0/0/%b",
                 name, bus.ready, bus.done, bus.hilo_stall, rd);
      end
      check_hilo({name, " hold-old"});
      tick();
    end
    bus.start = 1'b0;
    checks++;
    if (cycles != DELAY + 1) begin
      errors++;
      $display("FAIL %s busy-len: got %0d cycles expected %0d", name, cycles, DELAY + 1);
    end
    {exp_hi, exp_lo} = p;
    check_hilo(name);
    checks++;
    if (bus.done !== 1'b1 || bus.ready !== 1'b1 || bus.hilo_stall !== 1'b0) begin
      errors++;
      $display("FAIL %s done: done=%b ready=%b stall=%b expected 1/1/0",
               name, bus.done, bus.ready, bus.hilo_stall);
    end
    bus.rd_req = 1'b0;
    $display("mul op=%0d a=%h b=%h -> hi=%h lo=%h", op, a, b, bus.hi, bus.lo);
  endtask

  task automatic run_move(input logic [1:0] op, input logic [W-1:0] v, input string name);
    bus.start = 1'b1; bus.op = op; bus.rs_val = v;
    tick();
    bus.start = 1'b0;
    if (op == 2'b10) exp_hi = v; else exp_lo = v;
    check_hilo(name);
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL %s flags: busy=%b done=%b expected 0/0", name, bus.busy, bus.done);
    end
    $display("move op=%0d v=%h -> hi=%h lo=%h", op, v, bus.hi, bus.lo);
  endtask

  task automatic expect_done_low(input string name);
    tick();
    checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL %s after: done=%b busy=%b expected 0/0", name, bus.done, bus.busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick();
    tick();
    exp_hi = '0; exp_lo = '0;
    check_hilo("reset");
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.ready !== 1'b1) begin
      errors++;
      $display("FAIL reset flags: busy=%b done=%b ready=%b expected 0/0/1",
               bus.busy, bus.done, bus.ready);
    end
    rst = 1'b1;
    tick();
    $display("reset released");
  endtask

  task automatic test_multu();
    run_mul(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, "multu_max");
    expect_done_low("multu_max");
  endtask

  task automatic test_mult_signed();
    run_mul(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, "mult_m1_m1");
    expect_done_low("mult_m1_m1");
    run_mul(2'b00, 32'hFFFF_FFFF, 32'h0000_0002, 1'b0, 1'b0, "mult_m1_2");
    expect_done_low("mult_m1_2");
    run_mul(2'b00, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, "mult_min_min");
    expect_done_low("mult_min_min");
    run_mul(2'b00, 32'h8000_0000, 32'h0000_0003, 1'b0, 1'b0, "mult_min_3");
    expect_done_low("mult_min_3");
  endtask

  task automatic test_move();
    run_move(2'b10, 32'h0000_1234, "mthi");
    run_move(2'b11, 32'h0000_5678, "mtlo");
  endtask

  task automatic test_flush();
    bus.start = 1'b1; bus.op = 2'b00; bus.rs_val = 32'd5; bus.rt_val = 32'd7;
    tick();
    bus.start = 1'b0;
    tick();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    check_hilo("flush_keep");
    checks++;
    if (bus.busy !== 1'b0 || bus.ready !== 1'b1 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL flush flags: busy=%b ready=%b done=%b expected 0/1/0",
               bus.busy, bus.ready, bus.done);
    end
    for (int i = 0; i < DELAY + 2; i++) begin
      tick();
      checks++;
      if (bus.done !== 1'b0) begin
        errors++;
        $display("FAIL flush no-done: done=%b expected 0", bus.done);
      end
    end
    check_hilo("flush_late");
    $display("flush mid-wait -> hi=%h lo=%h", bus.hi, bus.lo);

    bus.start = 1'b1; bus.op = 2'b10; bus.rs_val = 32'hDEAD_BEEF; bus.flush = 1'b1;
    tick();
    bus.start = 1'b0; bus.flush = 1'b0;
    check_hilo("flush_drops_mthi");
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL flush_drops_mthi busy=%b expected 0", bus.busy);
    end
    $display("flush with mthi -> hi=%h", bus.hi);

    bus.start = 1'b1; bus.op = 2'b00; bus.rs_val = 32'd5; bus.rt_val = 32'd7;
    tick();
    bus.start = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    exp_hi = '0; exp_lo = '0;
    check_hilo("reset_mid_wait");
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_wait flags: busy=%b done=%b expected 0/0", bus.busy, bus.done);
    end
    expect_done_low("reset_mid_wait");
    $display("reset mid-wait -> hi=%h lo=%h", bus.hi, bus.lo);
  endtask

  task automatic test_stall_and_ignore();
    run_mul(2'b01, 32'd1000, 32'd3000, 1'b1, 1'b1, "stall_hold_start");
    expect_done_low("stall_hold_start");
    check_hilo("ignored_start");
  endtask

  task automatic test_back_to_back();
    run_mul(2'b00, 32'hFFFF_FFF9, 32'd6, 1'b0, 1'b0, "b2b_first");
    run_mul(2'b01, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 1'b0, "b2b_second");
    run_move(2'b11, 32'hCAFE_0001, "b2b_mtlo");
  endtask

  task automatic test_random();
    logic [1:0] op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    for (int n = 0; n < 40; n++) begin
      op = 2'($urandom_range(0, 3));
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 4) == 0) a = 32'h8000_0000;
      if ($urandom_range(0, 4) == 0) b = 32'hFFFF_FFFF;
      if (op[1]) begin
        run_move(op, a, "rand_move");
      end else begin
        run_mul(op, a, b, 1'($urandom_range(0, 1)), 1'b0, "rand_mul");
        if ($urandom_range(0, 1) == 1) expect_done_low("rand_mul");
      end
    end
    expect_done_low("rand_end");
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0;
    bus.start = 1'b0; bus.op = 2'b00; bus.rs_val = '0; bus.rt_val = '0;
    bus.flush = 1'b0; bus.rd_req = 1'b0;
    test_reset();
    test_multu();
    test_mult_signed();
    test_move();
    test_flush();
    test_stall_and_ignore();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
